// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D sequencing interface.
// Optional brake channel is enabled by defining A2D_BRAKE_EN.
package a2d_pkg;

   typedef enum logic [2:0] {IDLE, CMD, GAP, READ, STORE} state_e;

   typedef enum logic [2:0] {
      CH_BATT   = 3'd0,
      CH_CURR   = 3'd1,
      CH_BRAKE  = 3'd3,
      CH_TORQUE = 3'd4
   } chan_e;

   typedef enum logic [1:0] {SPI_IDLE, SPI_FRONT, SPI_SHIFT, SPI_BACK} spi_state_e;

   // SCLK = div[4]; preload leaves SCLK high for 8 clks before the first fall
   localparam logic [4:0] DIV_PRELOAD = 5'b10111;
   localparam logic [4:0] DIV_SMPL    = 5'b01111;
   localparam logic [4:0] DIV_SHFT    = 5'b11111;

   localparam int TMR_W_SLOW = 14;
   localparam int TMR_W_FAST = 9;

   function automatic chan_e next_chan(input chan_e ch);
      case (ch)
         CH_BATT:   return CH_CURR;
`ifdef A2D_BRAKE_EN
         CH_CURR:   return CH_BRAKE;
`else
         CH_CURR:   return CH_TORQUE;
`endif
         CH_BRAKE:  return CH_TORQUE;
         default:   return CH_BATT;
      endcase
   endfunction

endpackage

// File: rtl/a2d_intf_spi_mnrch.sv
// SPI master for the A2D: 16-bit full-duplex transfer, SCLK = clk/32, idles high.
// Transmit and receive share one shift register; MISO is double-flopped.
module spi_mnrch
   import a2d_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wrt,
   input  logic [15:0] wt_data,
   input  logic        MISO,
   output logic        done,
   output logic [15:0] rd_data,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI
);

   spi_state_e  st, nxt_st;
   logic [4:0]  div;
   logic [15:0] shift_reg;
   logic [3:0]  bit_cnt;
   logic        miso_p0, miso_p1, miso_smpl;
   logic        smpl_slot, shft_slot, do_shift, finish;

   assign smpl_slot = (div == DIV_SMPL);
   assign shft_slot = (div == DIV_SHFT);
   assign SCLK      = div[4];
   assign MOSI      = shift_reg[15];
   assign rd_data   = shift_reg;

   // The first SCLK fall only opens the frame; the final slot shifts in bit 16 without a fall
   always_comb begin
      nxt_st   = st;
      do_shift = 1'b0;
      finish   = 1'b0;
      case (st)
         SPI_IDLE:  if (wrt) nxt_st = SPI_FRONT;
         SPI_FRONT: if (shft_slot) nxt_st = SPI_SHIFT;
         SPI_SHIFT: begin
            do_shift = shft_slot;
            if (smpl_slot && bit_cnt == 4'hF) nxt_st = SPI_BACK;
         end
         SPI_BACK: begin
            if (shft_slot) begin
               do_shift = 1'b1;
               finish   = 1'b1;
               nxt_st   = SPI_IDLE;
            end
         end
         default: nxt_st = SPI_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st <= SPI_IDLE;
      else     st <= nxt_st;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         SS_n      <= 1'b1;
         div       <= DIV_PRELOAD;
         shift_reg <= '0;
         bit_cnt   <= '0;
         miso_p0   <= 1'b0;
         miso_p1   <= 1'b0;
         miso_smpl <= 1'b0;
         done      <= 1'b0;
      end else begin
         miso_p0 <= MISO;
         miso_p1 <= miso_p0;
         done    <= finish;
         if (st == SPI_IDLE) begin
            if (wrt) begin
               SS_n      <= 1'b0;
               div       <= DIV_PRELOAD;
               shift_reg <= wt_data;
               bit_cnt   <= '0;
            end
         end else begin
            div <= finish ? DIV_PRELOAD : div + 5'd1;
            if (finish) SS_n <= 1'b1;
            if (smpl_slot && st == SPI_SHIFT) begin
               miso_smpl <= miso_p1;
               bit_cnt   <= bit_cnt + 4'd1;
            end
            if (do_shift) shift_reg <= {shift_reg[14:0], miso_smpl};
         end
      end
   end

endmodule

// File: rtl/a2d_intf.sv
// Periodic round-robin A2D sampler: one CMD + READ SPI pair per timer wrap.
// Define A2D_BRAKE_EN to include the brake channel (3) in the rotation.
module a2d_intf
   import a2d_pkg::*;
#(
   parameter int FAST_SIM = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MISO,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   output logic [11:0] batt,
   output logic [11:0] curr,
   output logic [11:0] brake,
   output logic [11:0] torque,
   output logic        cnv_cmplt
);

   localparam int TMR_W = (FAST_SIM != 0) ? TMR_W_FAST : TMR_W_SLOW;

   state_e           state, nxt_state;
   chan_e            chan;
   logic [TMR_W-1:0] timer;
   logic             tmr_wrap;
   logic             gap_cnt;
   logic             wrt, done, load;
   logic [15:0]      wt_data, rd_data;
   logic             unused_rd_hi;

   assign tmr_wrap     = &timer;
   assign unused_rd_hi = ^rd_data[15:12];

   spi_mnrch u_spi (
      .clk     (clk),
      .rst     (rst),
      .wrt     (wrt),
      .wt_data (wt_data),
      .MISO    (MISO),
      .done    (done),
      .rd_data (rd_data),
      .SS_n    (SS_n),
      .SCLK    (SCLK),
      .MOSI    (MOSI)
   );

   // Wraps outside IDLE are dropped, so conversions never queue
   always_comb begin
      nxt_state = state;
      wrt       = 1'b0;
      wt_data   = 16'h0000;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (tmr_wrap) begin
               wrt       = 1'b1;
               wt_data   = {2'b00, chan, 11'h000};
               nxt_state = CMD;
            end
         end
         CMD:  if (done) nxt_state = GAP;
         GAP: begin
            if (gap_cnt) begin
               wrt       = 1'b1;
               nxt_state = READ;
            end
         end
         READ: if (done) nxt_state = STORE;
         STORE: begin
            load      = 1'b1;
            nxt_state = IDLE;
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         timer   <= '0;
         chan    <= CH_BATT;
         gap_cnt <= 1'b0;
      end else begin
         state   <= nxt_state;
         timer   <= timer + 1'b1;
         gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : 1'b0;
         if (load) chan <= next_chan(chan);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         batt      <= 12'h000;
         curr      <= 12'h000;
         torque    <= 12'h000;
         cnv_cmplt <= 1'b0;
      end else begin
         cnv_cmplt <= load;
         if (load) begin
            case (chan)
               CH_BATT:   batt   <= rd_data[11:0];
               CH_CURR:   curr   <= rd_data[11:0];
               CH_TORQUE: torque <= rd_data[11:0];
               default:   ;
            endcase
         end
      end
   end

`ifdef A2D_BRAKE_EN
   // Reset to full scale: brake reads as released until first measured
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          brake <= 12'hFFF;
      else if (load && chan == CH_BRAKE) brake <= rd_data[11:0];
   end
`else
   assign brake = 12'hFFF;
`endif

endmodule

// File: tb/tb_a2d_intf.sv
// Scoreboard bench for a2d_intf (FAST_SIM=1) with a behavioural A2D slave.
// Honours A2D_BRAKE_EN for the expected channel rotation.
module tb_a2d_intf;

   localparam time T = 10;

`ifdef A2D_BRAKE_EN
   localparam int NCH = 4;
`else
   localparam int NCH = 3;
`endif

   typedef struct {
      logic [11:0] b;
      logic [11:0] c;
      logic [11:0] k;
      logic [11:0] t;
   } regs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        MISO = 1'b0;
   logic        SS_n, SCLK, MOSI, cnv_cmplt;
   logic [11:0] batt, curr, brake, torque;

   always #(T/2) clk = ~clk;

   a2d_intf #(.FAST_SIM(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .MISO      (MISO),
      .SS_n      (SS_n),
      .SCLK      (SCLK),
      .MOSI      (MOSI),
      .batt      (batt),
      .curr      (curr),
      .brake     (brake),
      .torque    (torque),
      .cnv_cmplt (cnv_cmplt)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Channel order as a plain list: batt, curr, [brake,] torque
   function automatic int rot_chan(input int idx);
`ifdef A2D_BRAKE_EN
      case (idx % 4)
         0: return 0;
         1: return 1;
         2: return 3;
         default: return 4;
      endcase
`else
      case (idx % 3)
         0: return 0;
         1: return 1;
         default: return 4;
      endcase
`endif
   endfunction

   // A2D slave model + stimulus: answers READ with the commanded channel's value
   regs_t       sb_q[$];
   logic [11:0] a2d_val [0:7];
   logic [11:0] exp_reg [0:7];
   logic [15:0] rx, tx;
   logic [2:0]  cmd_ch;
   logic        ss_q = 1'b1, sclk_q = 1'b1;
   bit          is_read = 1'b0;
   int          nrise = 0, nfall = 0, conv_idx = 0, ch;
   time         t_rise = 0, t_ss_up = 0;

   always begin
      @(SS_n or SCLK or rst);
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            a2d_val[i] = 12'h000;
            exp_reg[i] = 12'h000;
         end
         a2d_val[0] = 12'h0A5;
         a2d_val[1] = 12'h7FF;
         a2d_val[3] = 12'($urandom);
         a2d_val[4] = 12'hFFF;
         exp_reg[3] = 12'hFFF;
         is_read    = 1'b0;
         conv_idx   = 0;
         nrise      = 0;
         sb_q.delete();
      end else begin
         if (ss_q && !SS_n) begin
            nrise = 0;
            nfall = 0;
            rx    = 16'h0000;
            if (is_read) begin
               check("gap_clks", 32'((($time - t_ss_up) / T)), 32'd3);
               tx = {4'($urandom), a2d_val[cmd_ch]};
            end else begin
               tx = 16'($urandom);
            end
            MISO = tx[15];
         end
         if (!SS_n && !sclk_q && SCLK) begin
            if (nrise > 0) check("sclk_period", 32'((($time - t_rise) / T)), 32'd32);
            t_rise = $time;
            rx     = {rx[14:0], MOSI};
            nrise++;
         end
         if (!SS_n && sclk_q && !SCLK) begin
            nfall++;
            if (nrise < 16) MISO = tx[15 - nrise];
         end
         if (!ss_q && SS_n) begin
            check("sclk_falls", nfall, 16);
            check("sclk_rises", nrise, 16);
            t_ss_up = $time;
            if (!is_read) begin
               check("cmd_word", {16'h0, rx}, 32'(rot_chan(conv_idx)) << 11);
               cmd_ch = rx[13:11];
               if (conv_idx >= NCH) a2d_val[cmd_ch] = 12'($urandom);
               is_read = 1'b1;
            end else begin
               ch          = rot_chan(conv_idx);
               exp_reg[ch] = a2d_val[ch];
               sb_q.push_back('{exp_reg[0], exp_reg[1], exp_reg[3], exp_reg[4]});
               conv_idx++;
               is_read = 1'b0;
            end
         end
      end
      ss_q   = SS_n;
      sclk_q = SCLK;
   end

   // Monitor: pops one expected register set per cnv_cmplt pulse
   int    n_pulse = 0, sclk_viol = 0;
   bit    prev_cnv = 1'b0;
   regs_t e;

   always @(negedge clk) begin
      if (!rst) begin
         if (prev_cnv) check("cnv_width", {31'h0, cnv_cmplt}, 32'd0);
         if (cnv_cmplt) begin
            n_pulse++;
            if (sb_q.size() == 0) begin
               n_chk++;
               $display("FAIL cnv_unexpected: pulse seen, scoreboard empty at %0t", $time);
            end else begin
               e = sb_q.pop_front();
               check("batt",   {20'h0, batt},   {20'h0, e.b});
               check("curr",   {20'h0, curr},   {20'h0, e.c});
               check("brake",  {20'h0, brake},  {20'h0, e.k});
               check("torque", {20'h0, torque}, {20'h0, e.t});
            end
         end
         if (SS_n && !SCLK) sclk_viol++;
         prev_cnv = cnv_cmplt;
      end else begin
         prev_cnv = 1'b0;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_SS_n"},  {31'h0, SS_n},      32'd1);
      check({tag, "_SCLK"},  {31'h0, SCLK},      32'd1);
      check({tag, "_MOSI"},  {31'h0, MOSI},      32'd0);
      check({tag, "_cnv"},   {31'h0, cnv_cmplt}, 32'd0);
      check({tag, "_batt"},  {20'h0, batt},      32'h000);
      check({tag, "_curr"},  {20'h0, curr},      32'h000);
      check({tag, "_brake"}, {20'h0, brake},     32'hFFF);
      check({tag, "_torq"},  {20'h0, torque},    32'h000);
   endtask

   int  base;
   bit  found;

   initial begin
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      rst = 1'b0;

      // Timer starts at 0 on release, so the first wrap lands on clk 512
      repeat (511) @(posedge clk);
      #1 check("ss_before_512", {31'h0, SS_n}, 32'd1);
      @(posedge clk);
      #1 check("ss_fall_512", {31'h0, SS_n}, 32'd0);

      for (int i = 0; i < 60000 && n_pulse < 2 * NCH; i++) @(posedge clk);
      check("convs_round1", n_pulse, 2 * NCH);

      found = 1'b0;
      for (int i = 0; i < 5000 && !found; i++) begin
         @(negedge clk);
         if (is_read && !SS_n && nrise == 8) found = 1'b1;
      end
      check("read_bit8_reached", {31'h0, found}, 32'd1);
      rst = 1'b1;
      #1 check_reset_outputs("abort");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      base = n_pulse;
      for (int i = 0; i < 20000 && n_pulse < base + 2; i++) @(posedge clk);
      check("convs_after_abort", n_pulse - base, 2);

      check("sb_drained", sb_q.size(), 0);
      check("sclk_high_when_idle", sclk_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/a2d_intf.md
A2D_INTF -- requirements
Module: a2d_intf

Interface
REQ-001 FAST_SIM, 0, when nonzero shortens the conversion interval for simulation.
REQ-002 clk  input  1  system clock; all flops on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 MISO  input  1  serial data from A2D.
REQ-005 SS_n  output  1  A2D slave select, active low.
REQ-006 SCLK  output  1  SPI clock, clk/32, idles high.
REQ-007 MOSI  output  1  serial command to A2D.
REQ-008 batt  output  12  latest channel-0 result.
REQ-009 curr  output  12  latest channel-1 result.
REQ-010 brake  output  12  latest channel-3 result; high value means brake released.
REQ-011 torque  output  12  latest channel-4 result.
REQ-012 cnv_cmplt  output  1  one-clk pulse when any result register updates.

Function
REQ-013 The interval timer SHALL be a free-running counter that starts one conversion each wrap: 2^14 clks with FAST_SIM=0, 2^9 clks otherwise.
REQ-014 The channel order SHALL be round-robin batt(0) -> curr(1) -> brake(3) -> torque(4) -> batt, advancing one channel per conversion.
REQ-015 Each conversion SHALL be two 16-bit SPI transactions: a CMD transaction sending {2'b00, ch[2:0], 11'h000}, and a READ transaction sending 16'h0000 whose received bits [11:0] are the result.
REQ-016 The FSM states SHALL be IDLE, CMD, GAP, READ and STORE.
REQ-017 Transitions: IDLE -> CMD on timer wrap; CMD -> GAP on SPI done; GAP -> READ after exactly 2 clks; READ -> STORE on SPI done; STORE -> IDLE in 1 clk.
REQ-018 In STORE, the result register of the current channel SHALL load; cnv_cmplt SHALL pulse; the channel pointer SHALL advance.
REQ-019 SPI transactions: SS_n falls on start; the divider loads 5'b10111; SCLK = div[4].
REQ-020 MISO SHALL be sampled when div==5'b01111 (SCLK rising), and the shift register SHALL shift when div==5'b11111 (SCLK falling).
REQ-021 MOSI SHALL be shift_reg[15]; transmit and receive SHALL use the same 16-bit register.
REQ-022 After the 16th sample, SCLK SHALL be held high, SS_n SHALL rise on the next falling-edge slot, and done SHALL assert for 1 clk.
REQ-023 A timer wrap occurring while not in IDLE SHALL be ignored; conversions never queue or overlap.
REQ-024 The channel pointer SHALL wrap from torque back to batt; other result registers SHALL hold their values.
REQ-025 MISO SHALL be double-flopped before sampling; this adds 2 clks of sample latency, which fits inside half an SCLK.

Reset
REQ-026 On rst: state=IDLE, timer=0, channel=batt.
REQ-027 On rst: SS_n=1, SCLK=1, MOSI=0, cnv_cmplt=0.
REQ-028 On rst: batt, curr and torque = 12'h000; brake = 12'hFFF.
REQ-029 Reset asserted mid-transaction SHALL abort immediately, and SS_n SHALL go high asynchronously.

Configuration
REQ-030 Macro A2D_BRAKE_EN defined: the rotation has 4 channels, as in REQ-014.
REQ-031 A2D_BRAKE_EN undefined: the rotation is batt -> curr -> torque, brake is constant 12'hFFF, and channel 3 is never commanded.

Structure
REQ-032 Package a2d_pkg SHALL hold the state enum, the channel enum with A2D codes (0, 1, 3, 4), the SCLK divider preload/slot constants, and the timer widths.
REQ-033 Sub-module spi_mnrch SHALL contain SS_n/SCLK/MOSI/MISO generation and the shift register, with ports clk, rst, wrt, wt_data[15:0], done, rd_data[15:0].

Verification
REQ-034 Reset release, FAST_SIM=1, A2D model returning 12'h0A5 on ch0 -> first SS_n fall at clk 512, CMD MOSI word 16'h0000, batt=12'h0A5, and cnv_cmplt pulses once.
REQ-035 Four consecutive conversions -> CMD words 16'h0000, 16'h0800, 16'h1800, 16'h2000, then 16'h0000 again.
REQ-036 Model values curr=12'h7FF and torque=12'hFFF -> those exact values appear, and no other register changes when each one updates.
REQ-037 During any transaction -> 16 SCLK falls per SS_n low, SCLK period 32 clks, SCLK high whenever SS_n is high, and a 2-clk GAP between CMD and READ.
REQ-038 Assert rst during READ bit 8 -> SS_n=1 and outputs at reset values the same cycle; after release, the next conversion is batt.
REQ-039 Build without A2D_BRAKE_EN -> CMD words 16'h0000, 16'h0800, 16'h2000 only, and brake stays 12'hFFF.
